arduino_mem_loader: RTL
=======================

// Module: arduino_mem_loader
// PURPOSE
//  Write-side counterpart of the Arduino read path. Accepts bytes from the Arduino
//  over an asynchronous 4-phase req/ack handshake and packs them low byte first into
//  16-bit words. Writes each word to the DRAM Arduino port at an auto-incrementing
//  20-bit address. Sits between the Arduino pins and the DRAM Arduino write port.
// PARAMETERS
//  ADDR_W      20    DRAM word-address width
//  DATA_W      16    DRAM word width; must equal 2*BYTE_W
//  BYTE_W      8     Arduino data bus width
//  NUM_WORDS   1024  words per load; done asserts after this many writes
//  SYNC_STAGES 2     flops in the req synchronizer (>=2)
// PORTS
//  clk          in   1       system clock
//  rst          in   1       asynchronous active-high reset
//  ard_req      in   1       Arduino request, asynchronous level
//  ard_data     in   BYTE_W  Arduino byte; stable while ard_req=1
//  ard_ack      out  1       acknowledge to Arduino
//  restart      in   1       sync pulse from core: addr/count to 0, clear done
//  arduinoAdd   out  ADDR_W  DRAM Arduino-port address
//  arduinoW     out  DATA_W  DRAM Arduino-port write data
//  ardwen       out  1       DRAM Arduino-port write enable, 1-cycle pulse
//  busy         out  1       1 while the FSM is not in S_IDLE/S_ARM
//  done         out  1       sticky; NUM_WORDS words written
//  word_count   out  ADDR_W  words written since reset/restart
// BEHAVIOUR
//  Reset values: all outputs 0; low-byte latch 0; byte phase = LO; FSM = S_ARM.
//  ard_req passes through SYNC_STAGES flops, all reset to 0; req_s = last stage.
//  ard_data is sampled only in S_LATCH. The handshake guarantees it is stable then.
//  FSM:
//   S_ARM   : wait for req_s=0, then go to S_IDLE. A req held high through reset is
//             never taken as a new byte.
//   S_IDLE  : go to S_LATCH when req_s=1.
//   S_LATCH : one cycle.
//             - Phase LO: store ard_data as the low byte; phase becomes HI.
//             - Phase HI: arduinoW={ard_data,lo}, ardwen=1 unless done; phase becomes LO.
//             - Always go to S_ACK.
//   S_ACK   : ard_ack=1; hold until req_s=0, then ack=0 and go to S_IDLE.
//  Write timing: arduinoAdd holds the target address during the ardwen cycle.
//   On the next edge, arduinoAdd and word_count increment.
//   When word_count reaches NUM_WORDS, done=1 and arduinoAdd wraps to 0.
//  Address wrap: arduinoAdd also wraps to 0 past 2**ADDR_W-1, regardless of NUM_WORDS.
//  Latency: req pin rise to ack rise = SYNC_STAGES+2 clk. req fall to ack fall = SYNC_STAGES+1.
//  When done=1: bytes are still acknowledged but ardwen stays 0 and the address is frozen.
//  restart=1 in any state:
//   - arduinoAdd=0, word_count=0, done=0, phase=LO.
//   - Any write in that same cycle is suppressed; restart has priority.
//   - The FSM state and ack are unaffected, so an in-progress handshake completes.
//  rst mid-handshake: ack drops immediately and the FSM returns to S_ARM.
//   A partial low byte is discarded.
//  Width rules: no truncation.
//   - word_count is ADDR_W wide; NUM_WORDS must be <= 2**ADDR_W (checked by elab assertion).
//   - DATA_W != 2*BYTE_W is an elaboration error.
// STRUCTURE
//  arduino_pkg: ADDR_W/DATA_W/BYTE_W constants, typedef enum logic[1:0]
//   {S_ARM,S_IDLE,S_LATCH,S_ACK} ld_state_t, typedef logic[ADDR_W-1:0] ard_addr_t.
//  Sub-module sync_nff (parameter STAGES, async reset) for the ard_req synchronizer.
//  Top level: FSM, byte packer, and address/count register. No other hierarchy.
// TESTING
//  1. Reset, then send bytes 0x34,0x12 -> ardwen pulses once with arduinoAdd=0,
//     arduinoW=0x1234; arduinoAdd=1 and word_count=1 on the next cycle.
//  2. Send 4 words 0xAAAA,0x5555,0x0001,0xFFFF -> writes at addrs 0..3 in order;
//     ack rise is SYNC_STAGES+2 clk after each req rise.
//  3. NUM_WORDS=4: send 5 words -> done=1 after the 4th write and arduinoAdd=0;
//     the 5th word is acknowledged with no ardwen.
//  4. Hold ard_req=1 across rst release -> no ack and no write until req falls and
//     rises again.
//  5. Send a low byte, then assert rst -> ack=0 and outputs 0. The next 2 bytes
//     0x78,0x56 write 0x5678 at address 0.
//  6. Pulse restart in the same cycle as a HI-phase S_LATCH at addr 7 -> no ardwen,
//     arduinoAdd=0, word_count=0, done=0; the handshake still completes.

Source files
------------

// File: rtl/arduino_pkg.sv
// +----------------------------------------------------------------------------+
// | arduino_pkg : shared widths and types for the Arduino DRAM load path         |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

package arduino_pkg;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        S_ARM   = 2'd0,
        S_IDLE  = 2'd1,
        S_LATCH = 2'd2,
        S_ACK   = 2'd3
    } ld_state_t;

    typedef enum logic {
        PH_LO = 1'b0,
        PH_HI = 1'b1
    } byte_phase_t;

    typedef logic [ADDR_W-1:0] ard_addr_t;

endpackage

`default_nettype wire

// File: rtl/sync_nff.sv
// +----------------------------------------------------------------------------+
// | sync_nff : N-flop level synchronizer with asynchronous active-high reset    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module sync_nff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    if (STAGES < 2) begin : g_chk_stages
        $fatal(1, "sync_nff: STAGES must be at least 2");
    end

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/arduino_mem_loader.sv
// +----------------------------------------------------------------------------+
// | arduino_mem_loader : packs Arduino req/ack bytes into 16-bit DRAM writes    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module arduino_mem_loader #(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16,
    parameter int BYTE_W      = 8,
    parameter int NUM_WORDS   = 1024,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ard_req,
    input  logic [BYTE_W-1:0] ard_data,
    output logic              ard_ack,
    input  logic              restart,
    output logic [ADDR_W-1:0] arduinoAdd,
    output logic [DATA_W-1:0] arduinoW,
    output logic              ardwen,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] word_count
);

    import arduino_pkg::*;

    if (DATA_W != 2 * BYTE_W) begin : g_chk_data_w
        $fatal(1, "arduino_mem_loader: DATA_W must equal 2*BYTE_W");
    end
    if (NUM_WORDS < 1 || longint'(NUM_WORDS) > (longint'(1) << ADDR_W)) begin : g_chk_num_words
        $fatal(1, "arduino_mem_loader: NUM_WORDS must be in 1..2**ADDR_W");
    end

    localparam int ARM_W = $clog2(SYNC_STAGES + 1);
    localparam logic [ARM_W-1:0]  ARM_DONE = ARM_W'(SYNC_STAGES);
    localparam logic [ADDR_W:0]   WORDS_END = (ADDR_W + 1)'(NUM_WORDS);

    logic req_s;

    sync_nff #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk (clk),
        .rst (rst),
        .d   (ard_req),
        .q   (req_s)
    );

    ld_state_t         state_q, state_d;
    byte_phase_t       phase_q, phase_d;
    logic [BYTE_W-1:0] lo_q, lo_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wen_q, wen_d;
    logic              ack_q, ack_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [ARM_W-1:0]  arm_q, arm_d;
    logic [ADDR_W:0]   count_inc;

    assign count_inc = {1'b0, count_q} + {{ADDR_W{1'b0}}, 1'b1};

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        lo_d    = lo_q;
        wdata_d = wdata_q;
        wen_d   = 1'b0;
        arm_d   = arm_q;
        addr_d  = addr_q;
        count_d = count_q;
        done_d  = done_q;

        case (state_q)
            // The synchronizer comes out of reset low, so wait for it to fill
            // before trusting req_s=0 as a genuine idle level.
            S_ARM: begin
                if (arm_q != ARM_DONE) begin
                    arm_d = arm_q + 1'b1;
                end else if (!req_s) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (req_s) begin
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                if (phase_q == PH_LO) begin
                    lo_d    = ard_data;
                    phase_d = PH_HI;
                end else begin
                    phase_d = PH_LO;
                    if (!done_q) begin
                        wdata_d = {ard_data, lo_q};
                        wen_d   = 1'b1;
                    end
                end
                state_d = S_ACK;
            end
            S_ACK: begin
                if (!req_s) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_ARM;
        endcase

        // Address advances on the edge that ends the write-enable cycle.
        if (wen_q) begin
            count_d = count_inc[ADDR_W-1:0];
            if (count_inc == WORDS_END) begin
                done_d = 1'b1;
                addr_d = '0;
            end else begin
                addr_d = addr_q + 1'b1;
            end
        end

        if (restart) begin
            addr_d  = '0;
            count_d = '0;
            done_d  = 1'b0;
            phase_d = PH_LO;
            wen_d   = 1'b0;
        end

        ack_d = (state_d == S_ACK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_ARM;
            phase_q <= PH_LO;
            lo_q    <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            count_q <= '0;
            arm_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            lo_q    <= lo_d;
            wdata_q <= wdata_d;
            wen_q   <= wen_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            arm_q   <= arm_d;
        end
    end

    assign ard_ack    = ack_q;
    assign arduinoAdd = addr_q;
    assign arduinoW   = wdata_q;
    assign ardwen     = wen_q & ~restart;
    assign busy       = (state_q == S_LATCH) || (state_q == S_ACK);
    assign done       = done_q;
    assign word_count = count_q;

endmodule

`default_nettype wire
